imm_gen_pipe: RTL and testbench

Parametrised, buffered immediate generator for the decode stage of the RISC-V pipeline CPU. It accepts instruction bits [31:7] with an immediate type code over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN bits, and queues results in a small FIFO so that decode can keep running while ID/EX is stalled. Flush support lets branch or jump resolution discard queued entries.

---
 rtl/imm_gen_pipe.sv | 137 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Buffered RISC-V immediate generator: computes the extended immediate on accept and queues it with type/tag.
// Optional macro IMM_ILLEGAL_CHK_EN adds a per-entry error bit for undefined type codes.
`ifndef ITYPE
`define ITYPE 3'd0
`endif
`ifndef STYPE
`define STYPE 3'd1
`endif
`ifndef BTYPE
`define BTYPE 3'd2
`endif
`ifndef UTYPE
`define UTYPE 3'd3
`endif
`ifndef JTYPE
`define JTYPE 3'd4
`endif
`ifndef ZTYPE
`define ZTYPE 3'd5
`endif

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      in_inst,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Formats are assembled at 64 bits and narrowed, so RV32 and RV64 share one table.
  function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:7] inst,
                                                     input logic [2:0]  typ);
    logic [63:0] w;
    logic        s;
    s = inst[31];
    w = '0;
    case (typ)
      `ITYPE: w = {{52{s}}, inst[31:20]};
      `STYPE: w = {{52{s}}, inst[31:25], inst[11:7]};
      `BTYPE: w = {{51{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      `JTYPE: w = {{44{s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      `UTYPE: w = {{32{s}}, inst[31:12], 12'b0};
      `ZTYPE: w = {59'b0, inst[19:15]};
      default: w = '0;
    endcase
    return w[XLEN-1:0];
  endfunction

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push, pop;
  logic signed [XLEN-1:0] imm_d;

  logic signed [XLEN-1:0] imm_mem_q  [DEPTH];
  logic [2:0]             type_mem_q [DEPTH];
  logic [TAG_W-1:0]       tag_mem_q  [DEPTH];

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign imm_d     = gen_imm(in_inst, in_type);

  always_comb begin
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      imm_mem_q[wr_ptr_q]  <= imm_d;
      type_mem_q[wr_ptr_q] <= in_type;
      tag_mem_q[wr_ptr_q]  <= in_tag;
    end
  end

  assign out_imm  = out_valid ? imm_mem_q[rd_ptr_q] : '0;
  assign out_type = type_mem_q[rd_ptr_q];
  assign out_tag  = tag_mem_q[rd_ptr_q];

`ifdef IMM_ILLEGAL_CHK_EN
  logic err_d;
  logic err_mem_q [DEPTH];

  assign err_d = (in_type > `ZTYPE);

  always_ff @(posedge clk) begin
    if (push && !flush) err_mem_q[wr_ptr_q] <= err_d;
  end

  assign out_err = out_valid && err_mem_q[rd_ptr_q];
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized self-checking bench for imm_gen_pipe against a FIFO-queue reference model.
`ifndef ITYPE
`define ITYPE 3'd0
`endif
`ifndef STYPE
`define STYPE 3'd1
`endif
`ifndef BTYPE
`define BTYPE 3'd2
`endif
`ifndef UTYPE
`define UTYPE 3'd3
`endif
`ifndef JTYPE
`define JTYPE 3'd4
`endif
`ifndef ZTYPE
`define ZTYPE 3'd5
`endif

module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:7]      in_inst;
  logic [2:0]       in_type, out_type;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [XLEN-1:0]  out_imm;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;
  ent_t q[$];

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_type(in_type), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_type(out_type), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference immediate from the format rules as signed integer arithmetic.
  function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] inst, input logic [2:0] t);
    longint v;
    v = 0;
    case (t)
      `ITYPE: begin v = longint'(inst[31:20]); if (inst[31]) v -= 4096; end
      `STYPE: begin v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]); if (inst[31]) v -= 4096; end
      `BTYPE: begin
        v = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
        if (inst[31]) v -= 4096;
      end
      `JTYPE: begin
        v = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
        if (inst[31]) v -= 64'sd1 <<< 20;
      end
      `UTYPE: begin v = longint'(inst[30:12]) * 4096; if (inst[31]) v -= 64'sd1 <<< 31; end
      `ZTYPE: v = longint'(inst[19:15]);
      default: v = 0;
    endcase
    return v[XLEN-1:0];
  endfunction

  function automatic logic ref_err(input logic [2:0] t);
`ifdef IMM_ILLEGAL_CHK_EN
    return (t == 3'd6) || (t == 3'd7);
`else
    return (t == 3'd7) && (t == 3'd6);
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_inst = '0; in_type = `ITYPE; in_tag = '0;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    nvec++; if (out_err !== 1'b0) begin nerr++; $display("FAIL reset_out_err got %0b want 0", out_err); end
  endtask

  task automatic test_formats();
    logic [31:0] insts [5];
    logic [2:0]  types [5];
    logic [63:0] want64 [5];
    logic [63:0] w;
    insts[0] = 32'hFFF00093; types[0] = `ITYPE; want64[0] = 64'hFFFFFFFFFFFFFFFF;
    insts[1] = 32'hFE000EE3; types[1] = `BTYPE; want64[1] = 64'hFFFFFFFFFFFFFFFC;
    insts[2] = 32'h800000B7; types[2] = `UTYPE; want64[2] = 64'hFFFFFFFF80000000;
    insts[3] = 32'h800F8000; types[3] = `ZTYPE; want64[3] = 64'h000000000000001F;
    insts[4] = 32'hFFFFFFFF; types[4] = 3'b111;  want64[4] = 64'h0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; out_ready = 1'b0;
      in_inst = insts[i][31:7]; in_type = types[i]; in_tag = TAG_W'(i + 3);
      tick();
      in_valid = 1'b0;
      w = want64[i];
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL fmt%0d_valid got %0b want 1", i, out_valid); end
      nvec++; if (out_imm !== w[XLEN-1:0]) begin nerr++; $display("FAIL fmt%0d_imm got %h want %h", i, out_imm, w[XLEN-1:0]); end
      nvec++; if (out_tag !== TAG_W'(i + 3)) begin nerr++; $display("FAIL fmt%0d_tag got %0d want %0d", i, out_tag, i + 3); end
      nvec++; if (out_err !== ref_err(types[i])) begin nerr++; $display("FAIL fmt%0d_err got %0b want %0b", i, out_err, ref_err(types[i])); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL fmt%0d_pop got %0b want 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 25'h0123456; in_type = `ITYPE;
    in_tag = 5'd1; tick();
    in_tag = 5'd2; tick();
    in_tag = 5'd3;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_full_ready got %0b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_still_full got %0b want 0", in_ready); end
    out_ready = 1'b1;
    nvec++; if (out_tag !== 5'd1) begin nerr++; $display("FAIL bp_head1 got %0d want 1", out_tag); end
    tick();
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_refused_push got ready %0b want 1", in_ready); end
    nvec++; if (out_tag !== 5'd2) begin nerr++; $display("FAIL bp_head2 got %0d want 2", out_tag); end
    tick();
    in_valid = 1'b0;
    nvec++; if (out_tag !== 5'd3 || out_valid !== 1'b1) begin nerr++; $display("FAIL bp_head3 got %0d/%0b want 3/1", out_tag, out_valid); end
    tick();
    out_ready = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drained got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_type = `ZTYPE; in_inst = 25'h1FFFFFF;
    in_tag = 5'd4; tick();
    in_tag = 5'd5; tick();
    flush = 1'b1; in_tag = 5'd9; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_ready got %0b want 1", in_ready); end
    tick();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_leak got %0b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] inst;
    logic        push, pop;
    ent_t        e;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      nvec++; if (out_valid !== (q.size() > 0)) begin nerr++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, out_valid, q.size() > 0); end
      nvec++; if (in_ready !== (q.size() < DEPTH)) begin nerr++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, in_ready, q.size() < DEPTH); end
      if (q.size() > 0) begin
        nvec++;
        if (out_imm !== q[0].imm || out_type !== q[0].typ || out_tag !== q[0].tag || out_err !== q[0].err) begin
          nerr++;
          $display("FAIL rnd_head c=%0d got %h/%0d/%0d/%0b want %h/%0d/%0d/%0b", c, out_imm, out_type,
                   out_tag, out_err, q[0].imm, q[0].typ, q[0].tag, q[0].err);
        end
      end
      inst      = $urandom;
      in_inst   = inst[31:7];
      in_type   = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      e.imm = ref_imm(inst, in_type); e.typ = in_type; e.tag = in_tag; e.err = ref_err(in_type);
      tick();
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
